// File: rtl/regfile_write_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter and its pending queue.
package regfile_write_arbiter_pkg;

  localparam int unsigned REG_IDX_W            = 5;
  localparam int unsigned DATA_W               = 32;
  localparam logic [REG_IDX_W-1:0] ZERO_REG    = '0;
  localparam int unsigned DEFAULT_DEPTH        = 2;
  localparam int unsigned DEFAULT_STARVE_LIMIT = 4;

  typedef struct packed {
    logic                 valid;
    logic [REG_IDX_W-1:0] dest;
    logic [DATA_W-1:0]    data;
  } pendEntry_t;

endpackage

// File: rtl/regfile_write_arbiter_wb_pending_fifo.sv
// Circular queue of pending multi-cycle results with per-entry valid bits,
// parallel destination compare for WAW squash and decode-stage hazard query.
module wb_pending_fifo
  import regfile_write_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic                 clock,
  input  logic                 resetN,
  input  logic                 enq,
  input  logic [REG_IDX_W-1:0] enqDest,
  input  logic [DATA_W-1:0]    enqData,
  input  logic                 deq,
  input  logic                 squashEn,
  input  logic [REG_IDX_W-1:0] squashDest,
  input  logic [REG_IDX_W-1:0] queryReg1,
  input  logic [REG_IDX_W-1:0] queryReg2,
  output logic                 queryHit,
  output logic                 notEmpty,
  output logic                 notFull,
  output pendEntry_t           head
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  pendEntry_t           mem [DEPTH];
  logic [PTR_W-1:0]     headPtr;
  logic [PTR_W-1:0]     tailPtr;
  logic [CNT_W-1:0]     count;

  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clock) begin
    if (!resetN) begin
      headPtr <= '0;
      tailPtr <= '0;
      count   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i].valid <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++)
        if (squashEn && mem[i].valid && mem[i].dest == squashDest) mem[i].valid <= 1'b0;
      // Popped slots lose their valid bit so stale entries never raise a query hit.
      if (deq) begin
        mem[headPtr].valid <= 1'b0;
        headPtr            <= nextPtr(headPtr);
      end
      if (enq) begin
        mem[tailPtr] <= '{valid: 1'b1, dest: enqDest, data: enqData};
        tailPtr      <= nextPtr(tailPtr);
      end
      count <= count + CNT_W'(enq) - CNT_W'(deq);
    end
  end

  always_comb begin
    queryHit = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++)
      if (mem[i].valid && mem[i].dest != ZERO_REG &&
          (mem[i].dest == queryReg1 || mem[i].dest == queryReg2))
        queryHit = 1'b1;
  end

  assign notEmpty = (count != '0);
  assign notFull  = (count != CNT_W'(DEPTH));
  assign head     = mem[headPtr];

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between pipeline write-back (priority)
// and buffered multi-cycle results; flags pending-destination reads and starvation.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH        = DEFAULT_DEPTH,
  parameter int unsigned STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 WB_RegWrite,
  input  logic [REG_IDX_W-1:0] WB_Dest,
  input  logic [DATA_W-1:0]    WB_Data,
  input  logic                 MD_Valid,
  input  logic [REG_IDX_W-1:0] MD_Dest,
  input  logic [DATA_W-1:0]    MD_Data,
  output logic                 MD_Ready,
  output logic                 RF_WriteEnable,
  output logic [REG_IDX_W-1:0] RF_WriteReg,
  output logic [DATA_W-1:0]    RF_WriteData,
  input  logic [REG_IDX_W-1:0] Query_Reg1,
  input  logic [REG_IDX_W-1:0] Query_Reg2,
  output logic                 Query_Hit,
  output logic                 Stall_Req
);

  localparam int unsigned SC_W = $clog2(STARVE_LIMIT + 1);

  logic            wbActive;
  logic            mdFire;
  logic            headLive;
  logic            directWrite;
  logic            enq;
  logic            deq;
  logic            notEmpty;
  logic            notFull;
  logic            queryHit;
  pendEntry_t      head;
  logic [SC_W-1:0] starveCnt;

  wb_pending_fifo #(.DEPTH(DEPTH)) uFifo (
    .clock      (Clock),
    .resetN     (Reset),
    .enq        (enq),
    .enqDest    (MD_Dest),
    .enqData    (MD_Data),
    .deq        (deq),
    .squashEn   (wbActive),
    .squashDest (WB_Dest),
    .queryReg1  (Query_Reg1),
    .queryReg2  (Query_Reg2),
    .queryHit   (queryHit),
    .notEmpty   (notEmpty),
    .notFull    (notFull),
    .head       (head)
  );

  assign MD_Ready  = Reset && notFull;
  assign Query_Hit = Reset && queryHit;

  always_comb begin
    wbActive       = WB_RegWrite && (WB_Dest != ZERO_REG);
    mdFire         = MD_Valid && MD_Ready;
    headLive       = notEmpty && head.valid;
    directWrite    = !wbActive && !notEmpty && mdFire && (MD_Dest != ZERO_REG);
    // A squashed head is popped even while write-back holds the port.
    deq            = Reset && notEmpty && (!head.valid || !wbActive);
    // The in-flight MD result is older than a same-cycle WB write to the same register.
    enq            = mdFire && (MD_Dest != ZERO_REG) && !directWrite &&
                     !(wbActive && MD_Dest == WB_Dest);
    RF_WriteEnable = 1'b0;
    RF_WriteReg    = '0;
    RF_WriteData   = '0;
    if (Reset) begin
      if (wbActive) begin
        RF_WriteEnable = 1'b1;
        RF_WriteReg    = WB_Dest;
        RF_WriteData   = WB_Data;
      end else if (headLive) begin
        RF_WriteEnable = 1'b1;
        RF_WriteReg    = head.dest;
        RF_WriteData   = head.data;
      end else if (directWrite) begin
        RF_WriteEnable = 1'b1;
        RF_WriteReg    = MD_Dest;
        RF_WriteData   = MD_Data;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      starveCnt <= '0;
      Stall_Req <= 1'b0;
    end else if (deq) begin
      starveCnt <= '0;
      Stall_Req <= 1'b0;
    end else if (headLive && wbActive) begin
      if (starveCnt != SC_W'(STARVE_LIMIT)) starveCnt <= starveCnt + 1'b1;
      if (starveCnt >= SC_W'(STARVE_LIMIT - 1)) Stall_Req <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed vector bench for regfile_write_arbiter (DEPTH=2, STARVE_LIMIT=4).
module tb_regfile_write_arbiter;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        WB_RegWrite = 1'b0;
  logic [4:0]  WB_Dest = '0;
  logic [31:0] WB_Data = '0;
  logic        MD_Valid = 1'b0;
  logic [4:0]  MD_Dest = '0;
  logic [31:0] MD_Data = '0;
  logic        MD_Ready;
  logic        RF_WriteEnable;
  logic [4:0]  RF_WriteReg;
  logic [31:0] RF_WriteData;
  logic [4:0]  Query_Reg1 = '0;
  logic [4:0]  Query_Reg2 = '0;
  logic        Query_Hit;
  logic        Stall_Req;

  int vecCount  = 0;
  int missCount = 0;

  always #5 Clock = ~Clock;

  regfile_write_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
    .Clock          (Clock),
    .Reset          (Reset),
    .WB_RegWrite    (WB_RegWrite),
    .WB_Dest        (WB_Dest),
    .WB_Data        (WB_Data),
    .MD_Valid       (MD_Valid),
    .MD_Dest        (MD_Dest),
    .MD_Data        (MD_Data),
    .MD_Ready       (MD_Ready),
    .RF_WriteEnable (RF_WriteEnable),
    .RF_WriteReg    (RF_WriteReg),
    .RF_WriteData   (RF_WriteData),
    .Query_Reg1     (Query_Reg1),
    .Query_Reg2     (Query_Reg2),
    .Query_Hit      (Query_Hit),
    .Stall_Req      (Stall_Req)
  );

  typedef struct {
    logic        rst;
    logic        wbW;
    logic [4:0]  wbDt;
    logic [31:0] wbD;
    logic        mdV;
    logic [4:0]  mdDt;
    logic [31:0] mdD;
    logic [4:0]  q1;
    logic [4:0]  q2;
    logic        eWe;
    logic [4:0]  eReg;
    logic [31:0] eData;
    logic        eRdy;
    logic        eHit;
    logic        eStall;
  } vec_t;

  function automatic vec_t mk(
    input logic rst, input logic wbW, input logic [4:0] wbDt, input logic [31:0] wbD,
    input logic mdV, input logic [4:0] mdDt, input logic [31:0] mdD,
    input logic [4:0] q1, input logic [4:0] q2,
    input logic eWe, input logic [4:0] eReg, input logic [31:0] eData,
    input logic eRdy, input logic eHit, input logic eStall);
    vec_t v;
    v.rst = rst; v.wbW = wbW; v.wbDt = wbDt; v.wbD = wbD;
    v.mdV = mdV; v.mdDt = mdDt; v.mdD = mdD; v.q1 = q1; v.q2 = q2;
    v.eWe = eWe; v.eReg = eReg; v.eData = eData;
    v.eRdy = eRdy; v.eHit = eHit; v.eStall = eStall;
    return v;
  endfunction

  // Drive one cycle's inputs after the falling edge, check combinational and
  // registered outputs before the rising edge that commits the cycle.
  task automatic applyVec(input vec_t v, input int tag);
    @(negedge Clock);
    Reset = v.rst; WB_RegWrite = v.wbW; WB_Dest = v.wbDt; WB_Data = v.wbD;
    MD_Valid = v.mdV; MD_Dest = v.mdDt; MD_Data = v.mdD;
    Query_Reg1 = v.q1; Query_Reg2 = v.q2;
    #2;
    vecCount++;
    if (RF_WriteEnable !== v.eWe ||
        (v.eWe && (RF_WriteReg !== v.eReg || RF_WriteData !== v.eData)) ||
        MD_Ready !== v.eRdy || Query_Hit !== v.eHit || Stall_Req !== v.eStall) begin
      missCount++;
      $display("FAIL vec%0d: got we=%0b reg=%0d data=%h rdy=%0b hit=%0b stall=%0b, expected we=%0b reg=%0d data=%h rdy=%0b hit=%0b stall=%0b",
               tag, RF_WriteEnable, RF_WriteReg, RF_WriteData, MD_Ready, Query_Hit, Stall_Req,
               v.eWe, v.eReg, v.eData, v.eRdy, v.eHit, v.eStall);
    end
  endtask

  vec_t vecs[$];

  initial begin
    //            rst wbW wbDt wbD           mdV mdDt mdD       q1  q2   eWe eReg eData         rdy hit stl
    vecs.push_back(mk(0, 0, 0,  32'h0,        0, 0,  32'h0,    0,  0,   0, 0,  32'h0,        0, 0, 0));
    vecs.push_back(mk(0, 1, 5,  32'h5555,     1, 9,  32'h9,    0,  0,   0, 0,  32'h0,        0, 0, 0));
    vecs.push_back(mk(1, 1, 5,  32'hAAAA0001, 0, 0,  32'h0,    0,  0,   1, 5,  32'hAAAA0001, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0,  32'h0,        1, 9,  32'h1234, 0,  0,   1, 9,  32'h1234,     1, 0, 0));
    vecs.push_back(mk(1, 1, 3,  32'h33,       1, 7,  32'h70,   8,  0,   1, 3,  32'h33,       1, 0, 0));
    vecs.push_back(mk(1, 1, 3,  32'h34,       1, 8,  32'h80,   8,  0,   1, 3,  32'h34,       1, 0, 0));
    vecs.push_back(mk(1, 1, 3,  32'h35,       1, 10, 32'hA0,   8,  0,   1, 3,  32'h35,       0, 1, 0));
    vecs.push_back(mk(1, 0, 0,  32'h0,        0, 0,  32'h0,    8,  7,   1, 7,  32'h70,       0, 1, 0));
    vecs.push_back(mk(1, 0, 0,  32'h0,        0, 0,  32'h0,    8,  0,   1, 8,  32'h80,       1, 1, 0));
    vecs.push_back(mk(1, 0, 0,  32'h0,        0, 0,  32'h0,    8,  0,   0, 0,  32'h0,        1, 0, 0));
    vecs.push_back(mk(1, 1, 1,  32'h11,       1, 4,  32'h40,   4,  0,   1, 1,  32'h11,       1, 0, 0));
    vecs.push_back(mk(1, 1, 4,  32'h44,       0, 0,  32'h0,    4,  0,   1, 4,  32'h44,       1, 1, 0));
    vecs.push_back(mk(1, 0, 0,  32'h0,        0, 0,  32'h0,    4,  0,   0, 0,  32'h0,        1, 0, 0));
    vecs.push_back(mk(1, 0, 0,  32'h0,        0, 0,  32'h0,    4,  0,   0, 0,  32'h0,        1, 0, 0));
    vecs.push_back(mk(1, 1, 6,  32'h66,       1, 6,  32'h60,   6,  0,   1, 6,  32'h66,       1, 0, 0));
    vecs.push_back(mk(1, 0, 0,  32'h0,        0, 0,  32'h0,    6,  0,   0, 0,  32'h0,        1, 0, 0));
    vecs.push_back(mk(1, 1, 0,  32'hDEAD,     1, 0,  32'hBEEF, 0,  0,   0, 0,  32'h0,        1, 0, 0));
    vecs.push_back(mk(1, 1, 0,  32'hDEAD,     1, 12, 32'hC0,   12, 0,   1, 12, 32'hC0,       1, 0, 0));
    vecs.push_back(mk(1, 1, 2,  32'h22,       1, 13, 32'hD0,   13, 0,   1, 2,  32'h22,       1, 0, 0));
    vecs.push_back(mk(1, 1, 2,  32'h23,       1, 14, 32'hE0,   13, 14,  1, 2,  32'h23,       1, 1, 0));
    vecs.push_back(mk(0, 0, 0,  32'h0,        0, 0,  32'h0,    13, 14,  0, 0,  32'h0,        0, 0, 0));
    vecs.push_back(mk(1, 0, 0,  32'h0,        0, 0,  32'h0,    13, 14,  0, 0,  32'h0,        1, 0, 0));
    vecs.push_back(mk(1, 0, 0,  32'h0,        0, 0,  32'h0,    0,  0,   0, 0,  32'h0,        1, 0, 0));

    Reset = 1'b0;
    repeat (2) @(posedge Clock);

    for (int i = 0; i < vecs.size(); i++) applyVec(vecs[i], i);

    // Starvation: one queued result blocked by four WB cycles raises Stall_Req,
    // which drops the cycle after the head finally drains.
    applyVec(mk(1, 1, 1, 32'h100, 1, 20, 32'h2000, 0, 0, 1, 1, 32'h100, 1, 0, 0), 100);
    for (int k = 1; k <= 4; k++)
      applyVec(mk(1, 1, 1, 32'h100 + 32'(k), 0, 0, 32'h0, 20, 0,
                  1, 1, 32'h100 + 32'(k), 1, 1, 0), 100 + k);
    applyVec(mk(1, 0, 0, 32'h0, 0, 0, 32'h0, 20, 0, 1, 20, 32'h2000, 1, 1, 1), 105);
    applyVec(mk(1, 0, 0, 32'h0, 0, 0, 32'h0, 20, 0, 0, 0, 32'h0, 1, 0, 0), 106);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the register file's single write port between the in-order pipeline write-back stage and a multi-cycle unit (multiply/divide) that returns results out of band. Pipeline write-back always has priority; multi-cycle results are buffered in a small pending queue and drained on idle write-back cycles. The block also flags decode-stage reads of still-pending destinations, and requests a pipeline bubble when a pending result starves. It sits between the write-back mux/multi-cycle unit and the register file write port.

## Interface
- DEPTH, 2, pending-queue entries (≥1)
- STARVE_LIMIT, 4, consecutive blocked cycles before a bubble is requested
- Clock  in  1  system clock, rising edge
- Reset  in  1  synchronous, active-low
- WB_RegWrite  in  1  pipeline write-back request
- WB_Dest  in  5  pipeline destination register
- WB_Data  in  32  pipeline write data (already mem/ALU muxed)
- MD_Valid  in  1  multi-cycle result offered
- MD_Dest  in  5  multi-cycle destination
- MD_Data  in  32  multi-cycle result
- MD_Ready  out  1  result accepted when MD_Valid & MD_Ready
- RF_WriteEnable  out  1  register-file write enable
- RF_WriteReg  out  5  register-file write address
- RF_WriteData  out  32  register-file write data
- Query_Reg1, Query_Reg2  in  5 each  decode-stage source registers
- Query_Hit  out  1  a source matches a pending destination
- Stall_Req  out  1  request one write-back bubble

## Operation
- Write port select, priority order: (1) WB_RegWrite with WB_Dest≠0; (2) valid queue head; (3) direct path: queue empty and MD handshake with MD_Dest≠0. Selected source drives RF_* combinationally; no source -> RF_WriteEnable=0.
- Writes to register 0 never reach the port: WB such writes treated as idle; MD such results accepted and discarded.
- MD result accepted but not written this cycle -> enqueued at tail.
- MD_Ready = (occupancy < DEPTH); no pass-through when full even if head drains same cycle.
- WAW squash: WB write to register r (r≠0) clears valid bit of every queued entry with dest r, and discards a same-cycle incoming MD result with dest r (multi-cycle result is older).
- Invalid (squashed) head popped in one cycle without a write, regardless of WB activity.
- Query_Hit = any valid queue entry with dest ≠0 equal to Query_Reg1 or Query_Reg2; combinational; excludes the current-cycle MD input.
- Starve counter: increments each cycle a valid head exists and is blocked by WB; clears when head is written or popped. Stall_Req registered, set when counter reaches STARVE_LIMIT; cleared the cycle after the head is written.

## Timing
- Pipeline write: zero-cycle latency, written at the edge ending the request cycle.
- Direct MD write: zero-cycle latency; queued MD write: ≥1 cycle.
- Enqueue, dequeue and squash in the same cycle all take effect at that edge; occupancy = old + enq − deq.
- Reset low (sampled at edge): queue emptied, all valid bits 0, counter 0, Stall_Req 0. While Reset low: RF_WriteEnable 0, MD_Ready 0, Query_Hit 0. Reset mid-drain discards queued results.
- First cycle after reset release: MD_Ready 1.

## Structure
- Shared package: REG_IDX_W=5, DATA_W=32, ZERO_REG=0, default DEPTH/STARVE_LIMIT, pending-entry struct {valid, dest, data}.
- Sub-module wb_pending_fifo: circular queue with per-entry valid bits, parallel dest-compare (squash and query), head/tail pointers wrapping at DEPTH. The arbiter holds the priority mux and starve counter.

## Test plan
- WB_RegWrite=1, WB_Dest=5, WB_Data=0xAAAA0001, MD idle -> same cycle RF_WriteEnable=1, RF_WriteReg=5, RF_WriteData=0xAAAA0001.
- WB idle, queue empty, MD_Valid with dest 9, data 0x1234 -> direct write same cycle, occupancy stays 0.
- WB busy 3 cycles to reg 3, MD results to 7 then 8 -> both queued, MD_Ready=0 when full, Query_Reg1=8 gives Query_Hit=1; WB idle -> writes 7, then 8 on consecutive cycles.
- Queued dest 4, WB writes reg 4 -> entry squashed, no later write to 4, Query_Hit for 4 clears next cycle.
- Queued head plus WB busy for STARVE_LIMIT=4 cycles -> Stall_Req=1 after the 4th; WB idle -> head written, Stall_Req 0 next cycle.
- MD dest 0 or WB dest 0 -> RF_WriteEnable never 1 for reg 0; Reset low with 2 queued -> queue empty, no write after release.
